// File: rtl/fetch_pipeline_skid.sv
// IF/ID pipeline register with redirect squash and a small skid FIFO for fetch words arriving under a decode stall.
// Latency: 1 cycle with an empty skid FIFO and no stall, otherwise 1 + fifo_count cycles.
// Backpressure: in_ready drops only when the skid FIFO is full; fetch must hold its word until accepted.
module fetch_pipeline_skid #(
  parameter int          XLEN         = 32,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          SKID_DEPTH   = 2,
  parameter logic [31:0] NOP_INSN     = 32'h00000013
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic [XLEN-1:0]                     instruction_fetch,
  input  logic [XLEN-1:0]                     pc_pre_address,
  output logic                                in_ready,
  input  logic                                Jal,
  input  logic                                Jalr,
  input  logic                                branch_result,
  input  logic                                load,
  output logic [XLEN-1:0]                     instruction,
  output logic [XLEN-1:0]                     pre_address,
  output logic                                out_valid,
  output logic                                flush_active,
  output logic [$clog2(SKID_DEPTH+1)-1:0]     fifo_count
);

  localparam int CW  = $clog2(SKID_DEPTH + 1);
  localparam int IW  = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int SQW = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(NOP_INSN);

  // Shift-style skid FIFO: entry 0 is always the oldest word (head).
  logic [XLEN-1:0] fifo_insn [0:(1<<IW)-1];
  logic [XLEN-1:0] fifo_pc   [0:(1<<IW)-1];
  logic [CW-1:0]   count;
  logic [SQW-1:0]  sq;

  logic          redirect;
  logic          accept;
  logic [CW-1:0] count_m1;
  logic [IW-1:0] wr_idx;

  // Redirect sources, acceptance and the FIFO write slot for this cycle.
  always_comb begin
    redirect = Jal | Jalr | branch_result;
    in_ready = (count != CW'(SKID_DEPTH));
    accept   = in_valid & in_ready;
    count_m1 = count - 1'b1;
    // Under a stall the new word lands after the last entry; when the head is
    // popped in the same cycle everything shifts down one slot first.
    wr_idx   = load ? count[IW-1:0] : count_m1[IW-1:0];
  end

  assign fifo_count   = count;
  assign flush_active = (sq != '0);

  // Output register, skid FIFO and squash counter, priority redirect > squash > stall > normal.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instruction <= NOP;
      pre_address <= '0;
      out_valid   <= 1'b0;
      count       <= '0;
      sq          <= '0;
      for (int i = 0; i < (1 << IW); i++) begin
        fifo_insn[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (redirect) begin
      instruction <= NOP;
      pre_address <= '0;
      out_valid   <= 1'b0;
      count       <= '0;
      sq          <= SQW'(FLUSH_CYCLES - 1);
    end else if (sq != '0) begin
      // Wrong-path words still arriving are swallowed; load does not matter here.
      instruction <= NOP;
      pre_address <= '0;
      out_valid   <= 1'b0;
      sq          <= sq - 1'b1;
    end else if (load) begin
      // Decode is stalled: output holds, the fetch word goes to the skid tail.
      if (accept) begin
        fifo_insn[wr_idx] <= instruction_fetch;
        fifo_pc[wr_idx]   <= pc_pre_address;
        count             <= count + 1'b1;
      end
    end else if (count != '0) begin
      // Drain the oldest buffered word first so program order is kept.
      instruction <= fifo_insn[0];
      pre_address <= fifo_pc[0];
      out_valid   <= 1'b1;
      for (int i = 0; i < SKID_DEPTH - 1; i++) begin
        fifo_insn[i] <= fifo_insn[i+1];
        fifo_pc[i]   <= fifo_pc[i+1];
      end
      if (accept) begin
        fifo_insn[wr_idx] <= instruction_fetch;
        fifo_pc[wr_idx]   <= pc_pre_address;
      end else begin
        count <= count_m1;
      end
    end else if (accept) begin
      instruction <= instruction_fetch;
      pre_address <= pc_pre_address;
      out_valid   <= 1'b1;
    end else begin
      instruction <= NOP;
      pre_address <= '0;
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: doc/fetch_pipeline_skid.md
# fetch_pipeline_skid

Parametrised IF/ID pipeline register between the instruction fetch unit and decode. It generalises the fixed 32-bit register to any XLEN and a configurable number of post-redirect squash cycles, and it uses a canonical NOP for bubbles. It adds valid tracking and a small skid FIFO, so fetch words that arrive while decode is stalled on a load are buffered instead of lost.

## Interface
- XLEN, 32, instruction and PC width
- FLUSH_CYCLES, 2, number of output bubbles forced by a redirect, counting the redirect cycle (legal 1..8)
- SKID_DEPTH, 2, skid FIFO entries (legal 1..4)
- NOP_INSN, 32'h00000013, bubble instruction (addi x0,x0,0); only its low XLEN bits are used
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents a word this cycle
- instruction_fetch  in  XLEN  fetched instruction
- pc_pre_address  in  XLEN  PC of the fetched instruction
- in_ready  out  1  block accepts the fetch word this cycle
- Jal, Jalr, branch_result  in  1 each  redirect requests; OR-ed together as `redirect`
- load  in  1  decode stall (load-use hazard)
- instruction  out  XLEN  instruction presented to decode (registered)
- pre_address  out  XLEN  PC presented to decode (registered)
- out_valid  out  1  `instruction` / `pre_address` carry a real instruction
- flush_active  out  1  squash counter is nonzero
- fifo_count  out  clog2(SKID_DEPTH+1)  skid FIFO occupancy

## Operation
- State:
  - output register {instruction, pre_address, out_valid}
  - skid FIFO of SKID_DEPTH {insn, pc} entries
  - squash counter `sq`
- in_ready = (fifo_count != SKID_DEPTH). This is combinational from registered state only.
- A fetch word is accepted when in_valid && in_ready.
- Priority per cycle is redirect > squash > stall > normal.
- **Redirect** (redirect=1):
  - Output register loads {NOP_INSN, 0, 0}.
  - FIFO is cleared.
  - sq loads FLUSH_CYCLES-1.
  - Any accepted input word is discarded.
  - A redirect during an active squash re-arms the counter.
- **Squash** (sq!=0, no redirect):
  - Output register loads {NOP_INSN, 0, 0}.
  - Accepted words are discarded.
  - sq decrements.
  - load is ignored.
- **Stall** (load=1, sq=0, no redirect):
  - Output register holds all fields, including out_valid.
  - An accepted word is pushed to the FIFO tail.
- **Normal** (load=0, sq=0, no redirect):
  - FIFO non-empty: output loads the FIFO head with out_valid=1, and the head is popped. An accepted word is pushed in the same cycle, so occupancy is unchanged.
  - FIFO empty and word accepted: the word bypasses to the output with out_valid=1.
  - FIFO empty and no word accepted: output loads {NOP_INSN, 0, 0}.
- Program order is preserved: FIFO contents always precede the current input.
- flush_active = (sq != 0).
- sq width is clog2(FLUSH_CYCLES)+1. It never underflows.

## Timing
- Reset (async assert, sync use after deassert): instruction=NOP_INSN, pre_address=0, out_valid=0, FIFO empty, fifo_count=0, sq=0, flush_active=0, in_ready=1.
- Reset asserted mid-stall or mid-squash clears all state immediately; buffered words are lost.
- Latency is 1 cycle from an accepted word to its appearance at the output when the FIFO is empty and there is no stall. With a non-empty FIFO, latency is 1 + fifo_count.
- A redirect at edge N produces bubbles at outputs after edges N .. N+FLUSH_CYCLES-1. The first word accepted in the cycle after edge N+FLUSH_CYCLES-1 appears at the output after the next edge.
- FIFO full during a stall drives in_ready=0. Fetch must hold its word, and no word is dropped or overwritten.
- A redirect while the FIFO is full clears it, and in_ready returns to 1 on the next cycle.
- load asserted with an empty FIFO and in_valid=0 holds the current output. A held bubble stays out_valid=0.

## Test plan
- **Reset and straight flow.** Deassert reset. Feed 0x00A00093 @pc 0x0, then 0x00100113 @pc 0x4 on consecutive cycles with load=0. Required: outputs appear one cycle later, each with out_valid=1, and fifo_count stays 0.
- **Stall with skid** (SKID_DEPTH=2). Hold load=1 for 3 cycles while feeding pcs 0x8, 0xC, 0x10. Required: output holds pc 0x4; fifo_count goes 1, 2; in_ready drops to 0 in the third cycle; pc 0x10 is held by fetch. After load falls, outputs are 0x8, 0xC, 0x10 in order with no gaps.
- **Redirect squash** (FLUSH_CYCLES=2). Pulse Jal at edge N with in_valid=1 in cycles N and N+1. Required: two bubbles {0x00000013, 0, 0}, flush_active=1 for one cycle, and the next accepted word appears after edge N+2.
- **Redirect while full.** Fill the FIFO under load, then assert branch_result with load still 1. Required: fifo_count becomes 0, out_valid=0, in_ready=1, and no buffered word ever reaches the output.
- **Back-to-back redirects.** Assert Jalr at edge N and Jal at edge N+1 (FLUSH_CYCLES=3). Required: bubbles continue through the output after edge N+3, with the counter re-armed at N+1.
- **Async reset mid-stall.** Assert rst low between edges while the FIFO holds 2 entries. Required: immediate fifo_count=0, out_valid=0, instruction=0x00000013.
